rs_symbol_pingpong_buffer: RTL and testbench



---
 rtl/rs_pkg.sv | 11 +
 rtl/rs_symbol_bank.sv | 30 +++
 rtl/rs_symbol_pingpong_buffer.sv | 119 +++++++++++
 tb/tb_rs_symbol_pingpong_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(15,11) decoder datapath.
package rs_pkg;

    localparam int RS_SYM_W = 4;
    localparam int RS_N     = 15;
    localparam int RS_K     = 11;
    localparam int RS_IDX_W = 4;

    typedef logic [RS_SYM_W-1:0] rs_sym_t;

endpackage

// File: rtl/rs_symbol_bank.sv
// One codeword-sized register array: single enabled write port and a
// combinational read port. Storage has no reset; contents are only
// meaningful once the control logic has marked the bank full.
module rs_symbol_bank
    import rs_pkg::*;
#(
    parameter int SYM_W = RS_SYM_W,
    parameter int DEPTH = RS_N,
    parameter int IDX_W = RS_IDX_W
) (
    input  logic             CLK,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [SYM_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [SYM_W-1:0] rdata_o
);

    logic [SYM_W-1:0] mem_q [DEPTH];

    // Capture one symbol per enabled cycle.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rs_symbol_pingpong_buffer.sv
// Two-bank ping-pong symbol store. One bank fills from the receiver while
// the other drains in arrival order to the error-correction adder.
//
// Handshakes: a symbol moves on a side only in a cycle where both valid and
// ready are high at the rising edge; valid never depends on ready, and data
// and index are held stable while valid is high and ready is low.
module rs_symbol_pingpong_buffer
    import rs_pkg::*;
#(
    parameter int SYM_W = RS_SYM_W,
    parameter int DEPTH = RS_N,
    parameter int IDX_W = RS_IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [1:0]       words_held
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]       full_q,    full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q,  rd_idx_d;

    logic             wr_fire;
    logic             rd_fire;
    logic [1:0]       bank_we;
    logic [SYM_W-1:0] bank_rdata [2];

    // Handshake qualifiers; a full bank is never written.
    assign in_ready  = !full_q[wr_bank_q] && !RESET && !flush;
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    assign bank_we[0] = wr_fire && (wr_bank_q == 1'b0);
    assign bank_we[1] = wr_fire && (wr_bank_q == 1'b1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        rs_symbol_bank #(
            .SYM_W (SYM_W),
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_bank (
            .CLK     (CLK),
            .we_i    (bank_we[b]),
            .waddr_i (wr_idx_q),
            .wdata_i (in_sym),
            .raddr_i (rd_idx_q),
            .rdata_o (bank_rdata[b])
        );
    end

    assign out_sym    = rd_bank_q ? bank_rdata[1] : bank_rdata[0];
    assign out_idx    = rd_idx_q;
    assign out_last   = out_valid && (rd_idx_q == LAST_IDX);
    assign words_held = {1'b0, full_q[0]} + {1'b0, full_q[1]};

    // Next-state for indices, bank pointers and full flags. A completing
    // write and a completing read always touch different banks, so both
    // flag updates can be applied in the same cycle.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;

        if (wr_fire) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IDX_ONE;
            end
        end

        if (rd_fire) begin
            if (rd_idx_q == LAST_IDX) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + IDX_ONE;
            end
        end
    end

    // Control registers; reset and flush both discard any partial codeword.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_rs_symbol_pingpong_buffer.sv
// Bench for the ping-pong symbol buffer: directed scenarios followed by a
// randomized phase, checked against a codeword-level reference model.
module tb_rs_symbol_pingpong_buffer;

  localparam int SYM_W = 4;
  localparam int DEPTH = 15;
  localparam int IDX_W = 4;

  // ---------------------------------------------------------------- clock/reset
  logic             CLK = 1'b0;
  logic             RESET;
  logic             flush;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [1:0]       words_held;

  always #5 CLK = ~CLK;

  rs_symbol_pingpong_buffer #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_sym     (in_sym),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sym    (out_sym),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .words_held (words_held)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  // Symbols of completed, not yet drained codewords, in release order.
  logic [SYM_W-1:0] exp_q[$];
  // Symbols of the codeword currently being received.
  logic [SYM_W-1:0] part_q[$];
  int held   = 0;   // complete codewords stored
  int rd_cnt = 0;   // symbols of the head codeword already released
  bit mon_en = 1'b0;

  bit               m_clear;
  bit               m_rdy;
  logic [SYM_W-1:0] m_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, compares against the model, then
  // advances the model by the handshakes that the next rising edge commits.
  always @(negedge CLK) begin
    if (mon_en) begin
      m_clear = RESET || flush;
      m_rdy   = (held < 2) && !m_clear;
      chk("in_ready",   {31'd0, in_ready},   {31'd0, m_rdy});
      chk("out_valid",  {31'd0, out_valid},  {31'd0, held > 0});
      chk("words_held", {30'd0, words_held}, held);
      chk("out_idx",    {28'd0, out_idx},    rd_cnt);
      chk("out_last",   {31'd0, out_last},   {31'd0, (held > 0) && (rd_cnt == DEPTH - 1)});
      if (held > 0) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 32'd1, 32'd0);
        end else begin
          m_head = exp_q[0];
          chk("out_sym", {28'd0, out_sym}, {28'd0, m_head});
        end
      end

      if (m_clear) begin
        exp_q.delete();
        part_q.delete();
        held   = 0;
        rd_cnt = 0;
      end else begin
        if ((held > 0) && out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rd_cnt++;
          if (rd_cnt == DEPTH) begin
            rd_cnt = 0;
            held--;
          end
        end
        if (in_valid && m_rdy) begin
          part_q.push_back(in_sym);
          if (part_q.size() == DEPTH) begin
            foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
            held++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic cyc(input logic v, input logic [SYM_W-1:0] s, input logic r);
    in_valid  = v;
    in_sym    = s;
    out_ready = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clear(input bit use_reset);
    in_valid = 1'b0;
    RESET    = use_reset;
    flush    = !use_reset;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    flush = 1'b0;
  endtask

  // Drain with out_ready steady (alt=0) or toggling 1010 (alt=1).
  task automatic drain(input bit alt);
    int n = 0;
    while (held > 0 && n < 400) begin
      cyc(1'b0, '0, alt ? ((n % 2) == 0) : 1'b1);
      n++;
    end
    cyc(1'b0, '0, 1'b0);
    chk("drain_timeout", {31'd0, held > 0}, 32'd0);
  endtask

  task automatic flush_scenario(input bit use_reset);
    for (int i = 0; i < 7; i++) cyc(1'b1, SYM_W'($urandom_range(0, 15)), 1'b0);
    pulse_clear(use_reset);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b0, '0, 1'b0);
    drain(1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    RESET     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = '0;
    out_ready = 1'b0;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc(1'b0, '0, 1'b0);

    // Fill bank 0 with 1..15, then bank 1 with 0xA, then offer a 31st symbol.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, SYM_W'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'hA, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h5, 1'b0);
    drain(1'b0);

    // Back-to-back streaming with incrementing data.
    for (int i = 0; i < 60; i++) cyc(1'b1, SYM_W'(i), 1'b1);
    drain(1'b0);

    // Stored codeword drained with out_ready toggling.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, SYM_W'($urandom_range(0, 15)), 1'b0);
    drain(1'b1);

    // Partial codeword discarded by flush, then by reset.
    flush_scenario(1'b0);
    flush_scenario(1'b1);

    // Randomized traffic with occasional flush/reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_clear(1'b1);
      end else if ($urandom_range(0, 99) == 0) begin
        pulse_clear(1'b0);
      end else begin
        cyc(($urandom_range(0, 3) != 0), SYM_W'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
      end
    end
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
